// File: rtl/stage_sequencer.sv
// Launch-vehicle stage sequencer: loads per-stage engine parameters, gates the
// engine reset around each burn and reports separation, coast, completion and timeout.
module stage_sequencer #(
    parameter int unsigned N                  = 64,
    parameter int unsigned SPECIFICIMPULSE_1  = 263,
    parameter int unsigned SPECIFICIMPULSE_2  = 421,
    parameter int unsigned SPECIFICIMPULSE_3  = 421,
    parameter int unsigned WEIGHT_PROPELLANT_1 = 2077000,
    parameter int unsigned WEIGHT_PROPELLANT_2 = 456100,
    parameter int unsigned WEIGHT_PROPELLANT_3 = 39136,
    parameter int unsigned WEIGHT_PROPELLANT_4 = 83864,
    parameter int unsigned BURNTIME_1         = 168,
    parameter int unsigned BURNTIME_2         = 360,
    parameter int unsigned BURNTIME_3         = 165,
    parameter int unsigned BURNTIME_4         = 335,
    parameter int unsigned WEIGHT_STAGE_1     = 137000,
    parameter int unsigned WEIGHT_STAGE_2     = 40100,
    parameter int unsigned WEIGHT_STAGE_3     = 15200,
    parameter int unsigned LM                 = 15103,
    parameter int unsigned CMSM               = 11900,
    parameter int unsigned COAST_CYCLES       = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 0
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic         ignition_end,
    output logic         engine_resetb,
    output logic [N-1:0] specificImpulse,
    output logic [N-1:0] initialWeight,
    output logic [N-1:0] propellantWeight,
    output logic [N-1:0] burntime,
    output logic [2:0]   stage_state,
    output logic         burning,
    output logic         detach,
    output logic         mission_done,
    output logic         fault
);
    localparam logic [N-1:0] PAY = N'(LM) + N'(CMSM);
    localparam logic [N-1:0] IW4 = N'(WEIGHT_PROPELLANT_4) + N'(WEIGHT_STAGE_3) + PAY;
    localparam logic [N-1:0] IW3 = N'(WEIGHT_PROPELLANT_3) + IW4;
    localparam logic [N-1:0] IW2 = N'(WEIGHT_PROPELLANT_2) + N'(WEIGHT_STAGE_2) + IW3;
    localparam logic [N-1:0] IW1 = N'(WEIGHT_PROPELLANT_1) + N'(WEIGHT_STAGE_1) + IW2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_BURN, S_SEPARATE, S_COAST, S_DONE, S_FAULT
    } state_t;

    state_t      state, n_state;
    logic [2:0]  n_idx;
    logic [31:0] burn_cnt, n_burn;
    logic [31:0] coast_cnt, n_coast;
    logic [N-1:0] n_isp, n_iw, n_pw, n_bt;

    always_comb begin
        n_state = state;
        n_idx   = stage_state;
        n_burn  = burn_cnt;
        n_coast = coast_cnt;
        case (state)
            S_IDLE: if (start) begin
                n_state = S_LOAD;
                n_idx   = 3'd1;
            end
            S_LOAD: begin
                n_state = S_BURN;
                n_burn  = '0;
            end
            S_BURN: begin
                // ignition_end takes priority over a timeout reached on the same cycle
                if (ignition_end) begin
                    if (stage_state == 3'd3) begin
                        n_state = S_COAST;
                        n_coast = '0;
                    end else if (stage_state == 3'd4) begin
                        n_state = S_DONE;
                    end else begin
                        n_state = S_SEPARATE;
                    end
                end else if (TIMEOUT_CYCLES != 0 &&
                             (burn_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES)) begin
                    n_state = S_FAULT;
                end else begin
                    n_burn = burn_cnt + 32'd1;
                end
            end
            S_SEPARATE: begin
                n_state = S_LOAD;
                n_idx   = stage_state + 3'd1;
            end
            S_COAST: begin
                if (coast_cnt == 32'(COAST_CYCLES - 1)) begin
                    n_state = S_LOAD;
                    n_idx   = 3'd4;
                end else begin
                    n_coast = coast_cnt + 32'd1;
                end
            end
            default: n_state = state;
        endcase
    end

    // Stage parameter table, applied when entering LOAD so outputs stay registered
    always_comb begin
        n_isp = specificImpulse;
        n_iw  = initialWeight;
        n_pw  = propellantWeight;
        n_bt  = burntime;
        if (n_state == S_LOAD) begin
            case (n_idx)
                3'd1: begin
                    n_isp = N'(SPECIFICIMPULSE_1); n_iw = IW1;
                    n_pw  = N'(WEIGHT_PROPELLANT_1); n_bt = N'(BURNTIME_1);
                end
                3'd2: begin
                    n_isp = N'(SPECIFICIMPULSE_2); n_iw = IW2;
                    n_pw  = N'(WEIGHT_PROPELLANT_2); n_bt = N'(BURNTIME_2);
                end
                3'd3: begin
                    n_isp = N'(SPECIFICIMPULSE_3); n_iw = IW3;
                    n_pw  = N'(WEIGHT_PROPELLANT_3); n_bt = N'(BURNTIME_3);
                end
                default: begin
                    n_isp = N'(SPECIFICIMPULSE_3); n_iw = IW4;
                    n_pw  = N'(WEIGHT_PROPELLANT_4); n_bt = N'(BURNTIME_4);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state            <= S_IDLE;
            stage_state      <= '0;
            burn_cnt         <= '0;
            coast_cnt        <= '0;
            specificImpulse  <= '0;
            initialWeight    <= '0;
            propellantWeight <= '0;
            burntime         <= N'(1);
            engine_resetb    <= 1'b0;
            burning          <= 1'b0;
            detach           <= 1'b0;
            mission_done     <= 1'b0;
            fault            <= 1'b0;
        end else begin
            state            <= n_state;
            stage_state      <= n_idx;
            burn_cnt         <= n_burn;
            coast_cnt        <= n_coast;
            specificImpulse  <= n_isp;
            initialWeight    <= n_iw;
            propellantWeight <= n_pw;
            burntime         <= n_bt;
            engine_resetb    <= (n_state == S_BURN);
            burning          <= (n_state == S_BURN);
            detach           <= (n_state == S_SEPARATE);
            mission_done     <= (n_state == S_DONE);
            fault            <= (n_state == S_FAULT);
        end
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: scoreboard of expected output events for the main
// mission flow, plus direct timing checks and a timeout instance.
module tb_stage_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_resetb, a_start, a_ign;
    logic a_er, a_burning, a_detach, a_done, a_fault;
    logic [63:0] a_isp, a_iw, a_pw, a_bt;
    logic [2:0]  a_st;

    logic b_resetb, b_start, b_ign;
    logic b_er, b_burning, b_detach, b_done, b_fault;
    logic [63:0] b_isp, b_iw, b_pw, b_bt;
    logic [2:0]  b_st;

    stage_sequencer dut_a (
        .clk(clk), .resetb(a_resetb), .start(a_start), .ignition_end(a_ign),
        .engine_resetb(a_er), .specificImpulse(a_isp), .initialWeight(a_iw),
        .propellantWeight(a_pw), .burntime(a_bt), .stage_state(a_st),
        .burning(a_burning), .detach(a_detach), .mission_done(a_done), .fault(a_fault));

    stage_sequencer #(.TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .resetb(b_resetb), .start(b_start), .ignition_end(b_ign),
        .engine_resetb(b_er), .specificImpulse(b_isp), .initialWeight(b_iw),
        .propellantWeight(b_pw), .burntime(b_bt), .stage_state(b_st),
        .burning(b_burning), .detach(b_detach), .mission_done(b_done), .fault(b_fault));

    typedef struct {
        logic [2:0]  st;
        logic [63:0] isp, iw, pw, bt;
        logic        det, done, er;
    } rec_t;

    rec_t q[$];
    int errors = 0;
    int checks = 0;

    function automatic rec_t mk(logic [2:0] st, logic [63:0] isp, logic [63:0] iw,
                                logic [63:0] pw, logic [63:0] bt, logic det, logic done);
        rec_t r;
        r.st = st; r.isp = isp; r.iw = iw; r.pw = pw; r.bt = bt;
        r.det = det; r.done = done; r.er = 1'b0;
        return r;
    endfunction

    function automatic rec_t stage_rec(int s, logic det, logic done);
        case (s)
            1: return mk(3'd1, 263, 2875403, 2077000, 168, det, done);
            2: return mk(3'd2, 421, 661403, 456100, 360, det, done);
            3: return mk(3'd3, 421, 165203, 39136, 165, det, done);
            default: return mk(3'd4, 421, 126067, 83864, 335, det, done);
        endcase
    endfunction

    function automatic rec_t reset_rec();
        return mk(3'd0, 0, 0, 0, 1, 1'b0, 1'b0);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output event on dut_a is matched against the queue head
    logic [2:0] prev_st = 3'd0;
    logic       prev_done = 1'b0;
    always @(negedge clk) begin
        rec_t e;
        if (a_detach || a_st != prev_st || (a_done && !prev_done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: st=%0d det=%0d done=%0d with empty queue",
                         a_st, a_detach, a_done);
            end else begin
                e = q.pop_front();
                if (a_st !== e.st || a_isp !== e.isp || a_iw !== e.iw || a_pw !== e.pw ||
                    a_bt !== e.bt || a_detach !== e.det || a_done !== e.done || a_er !== e.er) begin
                    errors++;
                    $display("FAIL sb_event: got st=%0d isp=%0d iw=%0d pw=%0d bt=%0d det=%0d done=%0d er=%0d expected st=%0d isp=%0d iw=%0d pw=%0d bt=%0d det=%0d done=%0d er=%0d",
                             a_st, a_isp, a_iw, a_pw, a_bt, a_detach, a_done, a_er,
                             e.st, e.isp, e.iw, e.pw, e.bt, e.det, e.done, e.er);
                end
            end
        end
        prev_st   = a_st;
        prev_done = a_done;
    end

    task automatic a_pulse_start();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic a_pulse_ign();
        @(negedge clk); a_ign = 1'b1;
        @(negedge clk); a_ign = 1'b0;
    endtask

    task automatic a_wait_burn(string name);
        int n = 0;
        while (!a_burning && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_burning) chk(name, 0, 1);
    endtask

    task automatic a_check_reset(string tag);
        chk({tag, "_er"}, a_er, 0);
        chk({tag, "_st"}, a_st, 0);
        chk({tag, "_iw"}, a_iw, 0);
        chk({tag, "_isp"}, a_isp, 0);
        chk({tag, "_pw"}, a_pw, 0);
        chk({tag, "_bt"}, a_bt, 1);
        chk({tag, "_flags"}, {a_burning, a_detach, a_done, a_fault}, 0);
    endtask

    initial begin
        int n;
        a_resetb = 1'b0; a_start = 1'b0; a_ign = 1'b0;
        b_resetb = 1'b0; b_start = 1'b0; b_ign = 1'b0;
        repeat (3) @(negedge clk);
        a_check_reset("rst");
        a_resetb = 1'b1; b_resetb = 1'b1;

        // Launch: LOAD one cycle, then engine released
        q.push_back(stage_rec(1, 0, 0));
        a_pulse_start();
        chk("load1_er", a_er, 0);
        @(negedge clk);
        chk("burn1_er", a_er, 1);
        chk("burn1_burning", a_burning, 1);

        // Stage 1 and 2 separations
        for (int s = 1; s <= 2; s++) begin
            repeat (4) @(negedge clk);
            q.push_back(stage_rec(s, 1, 0));
            q.push_back(stage_rec(s + 1, 0, 0));
            a_pulse_ign();
            chk("sep_detach", a_detach, 1);
            chk("sep_er", a_er, 0);
            a_wait_burn("sep_to_burn_timeout");
        end

        // Stage 3 burn end: coast with engine held in reset, no detach
        repeat (3) @(negedge clk);
        q.push_back(stage_rec(4, 0, 0));
        a_pulse_ign();
        n = 0;
        for (int i = 0; i < 20 && a_st == 3'd3; i++) begin
            if (!a_er && !a_detach && !a_burning) n++;
            @(negedge clk);
        end
        chk("coast_cycles", n, 4);
        chk("coast_load4_st", a_st, 4);
        chk("coast_load4_er", a_er, 0);
        a_wait_burn("burn4_timeout");

        // Stage 4 burn end: mission complete, sticky, start ignored
        repeat (3) @(negedge clk);
        q.push_back(stage_rec(4, 0, 1));
        a_pulse_ign();
        chk("done_flag", a_done, 1);
        chk("done_er", a_er, 0);
        a_pulse_start();
        repeat (3) @(negedge clk);
        chk("done_sticky", a_done, 1);
        chk("done_st", a_st, 4);
        chk("done_er_hold", a_er, 0);
        chk("done_burning", a_burning, 0);

        // Reset from DONE, relaunch, reset asynchronously mid-burn of stage 2
        q.push_back(reset_rec());
        a_resetb = 1'b0;
        repeat (2) @(negedge clk);
        a_resetb = 1'b1;
        q.push_back(stage_rec(1, 0, 0));
        a_pulse_start();
        a_wait_burn("relaunch_burn_timeout");
        q.push_back(stage_rec(1, 1, 0));
        q.push_back(stage_rec(2, 0, 0));
        a_pulse_ign();
        a_wait_burn("burn2_timeout");
        repeat (2) @(negedge clk);
        chk("midburn_pre_er", a_er, 1);
        q.push_back(reset_rec());
        #2 a_resetb = 1'b0;
        #1 a_check_reset("async");
        repeat (2) @(negedge clk);
        a_resetb = 1'b1;
        q.push_back(stage_rec(1, 0, 0));
        a_pulse_start();
        chk("relaunch_st", a_st, 1);
        chk("relaunch_iw", a_iw, 2875403);
        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        // Timeout instance: no ignition_end, fault after 10 BURN cycles
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("to_pre_fault", b_fault, 0);
        chk("to_pre_burning", b_burning, 1);
        @(negedge clk);
        chk("to_fault", b_fault, 1);
        chk("to_fault_er", b_er, 0);
        chk("to_fault_burning", b_burning, 0);
        repeat (3) @(negedge clk);
        chk("to_fault_sticky", b_fault, 1);

        // ignition_end on the 10th BURN cycle wins over the timeout
        b_resetb = 1'b0;
        repeat (2) @(negedge clk);
        b_resetb = 1'b1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (10) @(negedge clk);
        b_ign = 1'b1;
        @(negedge clk); b_ign = 1'b0;
        chk("tie_fault", b_fault, 0);
        chk("tie_detach", b_detach, 1);
        @(negedge clk);
        chk("tie_next_st", b_st, 2);
        chk("tie_next_iw", b_iw, 661403);
        chk("tie_fault_after", b_fault, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Synthesizable launch-vehicle stage sequencer. It is the initiator side of the `getVelocity` engine interface. It loads per-stage specific impulse, initial weight, propellant weight and burn time into the engine, holds the engine in reset between burns, and releases it for each burn. It advances on the engine's `ignition_end` and emits separation and coast events. It sits between the mission top level and `getVelocity`, and replaces the ad-hoc stage logic at bench level.

## Interface
Parameters:
- `N`, 64: width of all numeric outputs.
- `SPECIFICIMPULSE_1..3`, 263 / 421 / 421: Isp in s. Stage 4 reuses `SPECIFICIMPULSE_3` (third-stage reignition).
- `WEIGHT_PROPELLANT_1..4`, 2077000 / 456100 / 39136 / 83864: propellant mass in kg.
- `BURNTIME_1..4`, 168 / 360 / 165 / 335: burn time in s, passed through to the engine.
- `WEIGHT_STAGE_1..3`, 137000 / 40100 / 15200: dry mass in kg.
- `LM`, 15103; `CMSM`, 11900: payload mass in kg.
- `COAST_CYCLES`, 4: cycles spent in COAST between burn 3 and burn 4. Must be ≥1.
- `TIMEOUT_CYCLES`, 0: maximum number of cycles allowed in BURN. 0 disables the timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `start` in 1: launch request. Sampled only in IDLE.
- `ignition_end` in 1: burn-complete level from the engine.
- `engine_resetb` out 1: active-low reset to the engine. High only in BURN.
- `specificImpulse`, `initialWeight`, `propellantWeight`, `burntime` out N: engine parameters.
- `stage_state` out 3: current stage, 0 = not launched, 1..4.
- `burning` out 1: high in BURN.
- `detach` out 1: one-cycle pulse at separation of stage 1 and of stage 2.
- `mission_done` out 1: sticky. Set after burn 4 completes.
- `fault` out 1: sticky burn-timeout flag.

## Operation
- States: IDLE, LOAD, BURN, SEPARATE, COAST, DONE, FAULT.
- All outputs are registered. They change only on clock edges or on reset assertion.
- IDLE: if `start`=1, go to LOAD with the stage index set to 1.
- LOAD (1 cycle):
  - `stage_state` takes the new index.
  - The four parameter outputs take that stage's values.
  - `engine_resetb`=0.
  - Next state is BURN.
- BURN:
  - `engine_resetb`=1, `burning`=1.
  - The burn counter increments each cycle.
  - When `ignition_end`=1: stage 1 or 2 goes to SEPARATE; stage 3 goes to COAST; stage 4 goes to DONE.
- SEPARATE (1 cycle): `detach`=1, `engine_resetb`=0. Next state is LOAD with index+1.
- COAST: `engine_resetb`=0. Lasts exactly `COAST_CYCLES` cycles, then goes to LOAD with index 4. There is no detach, because the same stage reignites.
- DONE: `mission_done`=1, `engine_resetb`=0. Stays until reset. `start` is ignored.
- FAULT: entered from BURN when the burn counter reaches `TIMEOUT_CYCLES` (nonzero) with `ignition_end`=0.
  - `fault`=1, `engine_resetb`=0, `burning`=0.
  - Stays until reset.
- `initialWeight` per stage is a constant computed at elaboration in N-bit unsigned arithmetic:
  - Stage 1: all propellant, all dry masses, `LM`, `CMSM`.
  - Stage 2: `WEIGHT_PROPELLANT_2..4`, `WEIGHT_STAGE_2..3`, `LM`, `CMSM`.
  - Stage 3: `WEIGHT_PROPELLANT_3..4`, `WEIGHT_STAGE_3`, `LM`, `CMSM`.
  - Stage 4: `WEIGHT_PROPELLANT_4`, `WEIGHT_STAGE_3`, `LM`, `CMSM`.
- `ignition_end` is ignored outside BURN. `start` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, `stage_state`=0, `specificImpulse`/`initialWeight`/`propellantWeight`=0, `burntime`=1 (avoids a zero divisor in the engine). All flags are 0, and `engine_resetb`=0.
- Reset asserted mid-burn: every output returns to its reset value immediately and asynchronously. `engine_resetb` drops with no clock.
- Start latency:
  - `start` sampled at edge k gives LOAD outputs at k.
  - BURN, with `engine_resetb`=1, follows at k+1.
- Separation latency:
  - `ignition_end` sampled at edge e in BURN of stage 1 or 2 gives SEPARATE at e (`detach`=1, `engine_resetb`=0).
  - LOAD follows at e+1 and BURN at e+2.
- Coast latency: `ignition_end` at edge e in stage 3 gives COAST during e..e+`COAST_CYCLES`-1 and LOAD at e+`COAST_CYCLES`.
- Every burn is preceded by at least one cycle with `engine_resetb`=0, so a held-high `ignition_end` from the engine clears before the next BURN.
- Simultaneous events: if `ignition_end`=1 on the same cycle the timeout count is reached, `ignition_end` wins and no fault is raised.
- Burn counter: 32 bits, cleared in LOAD.

## Test plan
- Reset, then `start`=1 for 1 cycle: `stage_state`=1, `initialWeight`=2875403, `propellantWeight`=2077000, `burntime`=168, `specificImpulse`=263. `engine_resetb` rises 1 cycle after LOAD.
- Pulse `ignition_end` in stage 1, then in stage 2: exactly one `detach` pulse each. Stage 2 loads `initialWeight`=661403; stage 3 loads 165203.
- `ignition_end` in stage 3 with `COAST_CYCLES`=4: `engine_resetb`=0 for 4 cycles with no `detach`. Stage 4 loads `initialWeight`=126067, `specificImpulse`=421, `burntime`=335.
- `ignition_end` in stage 4: `mission_done`=1 and sticky, `engine_resetb`=0. A later `start` has no effect.
- `TIMEOUT_CYCLES`=10 with no `ignition_end`: `fault`=1 after 10 BURN cycles. Repeat with `ignition_end` on the 10th cycle: no fault, and stage 2 follows.
- `resetb` pulled low mid-BURN of stage 2 with no clock edge: all outputs at reset values within the same time step. `start` then relaunches from stage 1.
